// File: rtl/feedback_suppressor_pkg.sv
// Shared definitions for the feedback suppressor gain scheduler.
// Holds the FSM state encoding, default datapath widths and a gain helper.
package feedback_suppressor_pkg;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned GAIN_W_DEF = 8;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_DETECT  = 3'd1;
    localparam logic [STATE_W-1:0] ST_ATTACK  = 3'd2;
    localparam logic [STATE_W-1:0] ST_HOLD    = 3'd3;
    localparam logic [STATE_W-1:0] ST_RELEASE = 3'd4;

    // Unity gain code for a given gain width.
    function automatic int unsigned gain_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/feedback_suppressor_ctrl_level_detect.sv
// fs_level_detect: combinational loudness test of one signed sample.
// Ports:
//   i_data  in  DATA_W  two's complement sample
//   o_loud  out 1       |i_data| >= THRESH (most-negative value saturates)
module fs_level_detect #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned THRESH = 96
) (
    input  logic [DATA_W-1:0] i_data,
    output logic              o_loud
);

    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};

    logic [DATA_W-1:0] w_neg;
    logic [DATA_W-1:0] w_mag;

    assign w_neg = ~i_data + DATA_W'(1);

    // The most-negative sample has no positive counterpart; clamp it.
    assign w_mag = !i_data[DATA_W-1]    ? i_data  :
                   (i_data == MOST_NEG) ? MAX_POS : w_neg;

    assign o_loud = (w_mag >= DATA_W'(THRESH));

endmodule

// File: rtl/feedback_suppressor_ctrl.sv
// feedback_suppressor_ctrl: howl detector and gain scheduler.
// Sequences IDLE -> DETECT -> ATTACK -> HOLD -> RELEASE on the valid sample stream.
// Ports:
//   i_clk, i_reset        sample clock, synchronous active-high reset
//   i_enable              0 forces IDLE and unity gain
//   i_valid, i_data       sample qualifier and signed sample
//   o_gain, o_gain_valid  registered gain code and its one-cycle strobe
//   o_state, o_active     current state encoding, 1 in ATTACK/HOLD/RELEASE
module feedback_suppressor_ctrl
    import feedback_suppressor_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned GAIN_W     = GAIN_W_DEF,
    parameter int unsigned THRESH     = 96,
    parameter int unsigned DETECT_CNT = 64,
    parameter int unsigned HOLD_CNT   = 256,
    parameter int unsigned STEP       = 8,
    parameter int unsigned GAIN_MIN   = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_valid,
    input  logic [DATA_W-1:0]  i_data,
    output logic [GAIN_W-1:0]  o_gain,
    output logic               o_gain_valid,
    output logic [STATE_W-1:0] o_state,
    output logic               o_active
);

    localparam int unsigned DET_W  = $clog2(DETECT_CNT);
    localparam int unsigned HOLD_W = (HOLD_CNT > 1) ? $clog2(HOLD_CNT) : 1;
    localparam int unsigned GX_W   = GAIN_W + 1;
    localparam logic [GAIN_W-1:0] GAIN_MAX_C = GAIN_W'(gain_max(GAIN_W));
    localparam logic [GAIN_W-1:0] GAIN_MIN_C = GAIN_W'(GAIN_MIN);

    logic [STATE_W-1:0] r_state;
    logic [GAIN_W-1:0]  r_gain;
    logic [DET_W-1:0]   r_det_cnt;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_gain_valid;
    logic               r_active;

    logic [STATE_W-1:0] w_state_nxt;
    logic [GAIN_W-1:0]  w_gain_nxt;
    logic [DET_W-1:0]   w_det_nxt;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic               w_loud;
    logic               w_det_last;
    logic               w_hold_last;
    logic [GX_W-1:0]    w_sub;
    logic [GX_W-1:0]    w_add;
    logic [GAIN_W-1:0]  w_down;
    logic [GAIN_W-1:0]  w_up;

    fs_level_detect #(
        .DATA_W (DATA_W),
        .THRESH (THRESH)
    ) u_level (
        .i_data (i_data),
        .o_loud (w_loud)
    );

    assign w_det_last  = (r_det_cnt  == DET_W'(DETECT_CNT - 1));
    assign w_hold_last = (r_hold_cnt == HOLD_W'(HOLD_CNT - 1));

    // One extra bit catches underflow (MSB set) and overflow before clamping.
    assign w_sub  = {1'b0, r_gain} - GX_W'(STEP);
    assign w_add  = {1'b0, r_gain} + GX_W'(STEP);
    assign w_down = (w_sub[GX_W-1] || (w_sub < GX_W'(GAIN_MIN))) ? GAIN_MIN_C : w_sub[GAIN_W-1:0];
    assign w_up   = (w_add > GX_W'(GAIN_MAX_C)) ? GAIN_MAX_C : w_add[GAIN_W-1:0];

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        if (!i_enable) begin
            w_state_nxt = ST_IDLE;
        end else if (i_valid) begin
            case (r_state)
                ST_IDLE:    if (w_loud) w_state_nxt = ST_DETECT;
                ST_DETECT: begin
                    if (!w_loud)         w_state_nxt = ST_IDLE;
                    else if (w_det_last) w_state_nxt = ST_ATTACK;
                end
                ST_ATTACK:  if (w_down == GAIN_MIN_C) w_state_nxt = ST_HOLD;
                ST_HOLD:    if (!w_loud && w_hold_last) w_state_nxt = ST_RELEASE;
                ST_RELEASE: begin
                    if (w_loud)                  w_state_nxt = ST_ATTACK;
                    else if (w_up == GAIN_MAX_C) w_state_nxt = ST_IDLE;
                end
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Gain and counter updates; values hold unless a valid sample arrives.
    always_comb begin
        w_gain_nxt = r_gain;
        w_det_nxt  = r_det_cnt;
        w_hold_nxt = r_hold_cnt;
        if (!i_enable) begin
            w_gain_nxt = GAIN_MAX_C;
            w_det_nxt  = '0;
            w_hold_nxt = '0;
        end else if (i_valid) begin
            case (r_state)
                ST_IDLE: begin
                    w_gain_nxt = GAIN_MAX_C;
                    w_det_nxt  = w_loud ? DET_W'(1) : '0;
                end
                ST_DETECT: begin
                    if (!w_loud || w_det_last) w_det_nxt = '0;
                    else                       w_det_nxt = r_det_cnt + DET_W'(1);
                end
                ST_ATTACK: begin
                    w_gain_nxt = w_down;
                    if (w_down == GAIN_MIN_C) w_hold_nxt = '0;
                end
                ST_HOLD: begin
                    if (w_loud || w_hold_last) w_hold_nxt = '0;
                    else                       w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
                ST_RELEASE: begin
                    if (!w_loud) w_gain_nxt = w_up;
                end
                default: begin
                    w_gain_nxt = GAIN_MAX_C;
                    w_det_nxt  = '0;
                    w_hold_nxt = '0;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_gain       <= GAIN_MAX_C;
            r_det_cnt    <= '0;
            r_hold_cnt   <= '0;
            r_gain_valid <= 1'b0;
            r_active     <= 1'b0;
        end else begin
            r_gain       <= w_gain_nxt;
            r_det_cnt    <= w_det_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_gain_valid <= i_valid;
            r_active     <= (w_state_nxt == ST_ATTACK) || (w_state_nxt == ST_HOLD) ||
                            (w_state_nxt == ST_RELEASE);
        end
    end

    assign o_gain       = r_gain;
    assign o_gain_valid = r_gain_valid;
    assign o_state      = r_state;
    assign o_active     = r_active;

endmodule

// File: tb/tb_feedback_suppressor_ctrl.sv
// Self-checking bench for feedback_suppressor_ctrl: vector table, corner sequences, random vs model.
module tb_feedback_suppressor_ctrl;

    localparam int NTBL = 35;

    typedef struct {
        bit         rst;
        bit         en;
        bit         vld;
        logic [7:0] data;
        int         st;
        int         gain;
        int         gv;
        int         act;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       vld;
    logic [7:0] data;
    logic [7:0] o_gain;
    logic       o_gv;
    logic [2:0] o_state;
    logic       o_active;

    int n_vec  = 0;
    int n_miss = 0;

    vec_t tbl [NTBL];

    // Reference model variables (0=IDLE,1=DETECT,2=ATTACK,3=HOLD,4=RELEASE).
    int m_mode, m_det, m_hold, m_gain, m_gv;

    feedback_suppressor_ctrl #(
        .DATA_W(8), .GAIN_W(8), .THRESH(96),
        .DETECT_CNT(4), .HOLD_CNT(8), .STEP(64), .GAIN_MIN(32)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_valid(vld), .i_data(data),
        .o_gain(o_gain), .o_gain_valid(o_gv), .o_state(o_state), .o_active(o_active)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit e, bit v, int d, int st, int g, int gv, int a);
        vec_t x;
        x.rst = r; x.en = e; x.vld = v; x.data = 8'(d);
        x.st = st; x.gain = g; x.gv = gv; x.act = a;
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int st, input int g, input int gv, input int a);
        chk({tag, ".state"},  int'(o_state),  st);
        chk({tag, ".gain"},   int'(o_gain),   g);
        chk({tag, ".gvalid"}, int'(o_gv),     gv);
        chk({tag, ".active"}, int'(o_active), a);
    endtask

    // Drive one cycle; outputs are sampled 1 time unit after the edge.
    task automatic apply(input bit r, input bit e, input bit v, input logic [7:0] d);
        rst = r; en = e; vld = v; data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int d);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b1, 1'b1, 8'(d));
    endtask

    function automatic bit is_loud(input logic [7:0] d);
        int v;
        v = int'($signed(d));
        if (v < 0) v = -v;
        if (v > 127) v = 127;
        return v >= 96;
    endfunction

    task automatic model_step(input bit r, input bit e, input bit v, input logic [7:0] d);
        bit l;
        l = is_loud(d);
        if (r) begin
            m_mode = 0; m_gain = 255; m_gv = 0; m_det = 0; m_hold = 0;
        end else if (!e) begin
            m_mode = 0; m_gain = 255; m_gv = int'(v); m_det = 0; m_hold = 0;
        end else begin
            m_gv = int'(v);
            if (v) begin
                case (m_mode)
                    0: begin
                        m_gain = 255;
                        if (l) begin m_mode = 1; m_det = 1; end
                    end
                    1: begin
                        if (!l)           begin m_mode = 0; m_det = 0; end
                        else if (m_det == 3) begin m_mode = 2; m_det = 0; end
                        else              m_det = m_det + 1;
                    end
                    2: begin
                        m_gain = (m_gain - 64 < 32) ? 32 : m_gain - 64;
                        if (m_gain == 32) begin m_mode = 3; m_hold = 0; end
                    end
                    3: begin
                        if (l)                m_hold = 0;
                        else if (m_hold == 7) begin m_mode = 4; m_hold = 0; end
                        else                  m_hold = m_hold + 1;
                    end
                    default: begin
                        if (l) m_mode = 2;
                        else begin
                            m_gain = (m_gain + 64 > 255) ? 255 : m_gain + 64;
                            if (m_gain == 255) m_mode = 0;
                        end
                    end
                endcase
            end
        end
    endtask

    initial begin
        bit         r, e, v;
        logic [7:0] d;
        int         bias;

        rst = 1'b1; en = 1'b1; vld = 1'b0; data = '0;

        // Vector table: reset, near-miss, trigger, attack, gap, hold/retrigger, release, threshold edge.
        tbl[0] = mk(1, 1, 1, 127, 0, 255, 0, 0);
        tbl[1] = mk(1, 1, 1, 127, 0, 255, 0, 0);
        for (int i = 2; i <= 4; i++) tbl[i] = mk(0, 1, 1, -100, 1, 255, 1, 0);
        tbl[5] = mk(0, 1, 1, 10, 0, 255, 1, 0);
        for (int i = 6; i <= 8; i++) tbl[i] = mk(0, 1, 1, 100, 1, 255, 1, 0);
        tbl[9]  = mk(0, 1, 1, 100, 2, 255, 1, 1);
        tbl[10] = mk(0, 1, 1, 0,   2, 191, 1, 1);
        tbl[11] = mk(0, 1, 1, 100, 2, 127, 1, 1);
        tbl[12] = mk(0, 1, 1, 0,   2, 63,  1, 1);
        tbl[13] = mk(0, 1, 1, 0,   3, 32,  1, 1);
        tbl[14] = mk(0, 1, 0, 100, 3, 32,  0, 1);
        for (int i = 15; i <= 19; i++) tbl[i] = mk(0, 1, 1, (i % 2 == 0) ? 95 : -95, 3, 32, 1, 1);
        tbl[20] = mk(0, 1, 1, -128, 3, 32, 1, 1);
        for (int i = 21; i <= 27; i++) tbl[i] = mk(0, 1, 1, (i % 2 == 0) ? 95 : -95, 3, 32, 1, 1);
        tbl[28] = mk(0, 1, 1, 5, 4, 32,  1, 1);
        tbl[29] = mk(0, 1, 1, 5, 4, 96,  1, 1);
        tbl[30] = mk(0, 1, 1, 5, 4, 160, 1, 1);
        tbl[31] = mk(0, 1, 1, 5, 4, 224, 1, 1);
        tbl[32] = mk(0, 1, 1, 5, 0, 255, 1, 0);
        tbl[33] = mk(0, 1, 1, -96, 1, 255, 1, 0);
        tbl[34] = mk(0, 1, 1, 95,  0, 255, 1, 0);

        for (int i = 0; i < NTBL; i++) begin
            apply(tbl[i].rst, tbl[i].en, tbl[i].vld, tbl[i].data);
            check_all($sformatf("tbl%0d", i), tbl[i].st, tbl[i].gain, tbl[i].gv, tbl[i].act);
        end

        // Release re-attack: loud sample in RELEASE keeps gain, then attack resumes from it.
        apply(1'b1, 1'b1, 1'b0, 8'd0);
        run(4, 100);
        run(4, 0);
        run(8, 0);
        run(2, 0);
        check_all("rel160", 4, 160, 1, 1);
        run(1, -100);
        check_all("reatk", 2, 160, 1, 1);
        run(1, 0);
        check_all("reatk2", 2, 96, 1, 1);

        // Disable mid-attack jumps straight to unity; counters restart afterwards.
        apply(1'b1, 1'b1, 1'b0, 8'd0);
        run(4, 100);
        run(2, 0);
        check_all("atk127", 2, 127, 1, 1);
        apply(1'b0, 1'b0, 1'b1, 8'd100);
        check_all("dis", 0, 255, 1, 0);
        apply(1'b0, 1'b0, 1'b0, 8'd100);
        check_all("dis_nov", 0, 255, 0, 0);
        run(3, 100);
        check_all("redet", 1, 255, 1, 0);
        run(1, 100);
        check_all("reatk3", 2, 255, 1, 1);
        run(1, 0);
        apply(1'b1, 1'b1, 1'b1, 8'd100);
        check_all("rst_mid", 0, 255, 0, 0);

        // Valid gaps in HOLD freeze everything, then the hold count resumes.
        apply(1'b1, 1'b1, 1'b0, 8'd0);
        run(4, 100);
        run(4, 0);
        run(3, 0);
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b1, 1'b0, 8'h80);
            check_all($sformatf("gap%0d", i), 3, 32, 0, 1);
        end
        run(4, 0);
        check_all("hold7", 3, 32, 1, 1);
        run(1, 0);
        check_all("hold_rel", 4, 32, 1, 1);

        // Randomized traffic against the reference model.
        apply(1'b1, 1'b1, 1'b0, 8'd0);
        model_step(1'b1, 1'b1, 1'b0, 8'd0);
        bias = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 12 == 0) bias = int'($urandom_range(0, 1));
            r = ($urandom_range(0, 150) == 0);
            e = ($urandom_range(0, 60) != 0);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                d = 8'($urandom);
            end else if (($urandom_range(0, 9) < 9) == (bias == 1)) begin
                d = 8'($urandom_range(96, 128));
                if ($urandom_range(0, 1) == 1) d = -d;
            end else begin
                d = 8'($urandom_range(0, 95));
                if ($urandom_range(0, 1) == 1) d = -d;
            end
            apply(r, e, v, d);
            model_step(r, e, v, d);
            check_all($sformatf("rnd%0d", i), m_mode, m_gain, m_gv,
                      (m_mode >= 2) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
